// File: rtl/mrjong_rom_loader.sv
// ROM download router and core reset sequencer for the Mr. Jong top level.
// Splits the ioctl byte stream into program, graphics and colour-PROM writes.
module mrjong_rom_loader #(
  parameter int PRG_SIZE   = 32768,
  parameter int GFX_SIZE   = 16384,
  parameter int PROM_SIZE  = 512,
  parameter int ROM_INDEX  = 0,
  parameter int RESET_HOLD = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ext_reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        prg_we,
  output logic        gfx_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        load_error
);

  localparam int TOTAL  = PRG_SIZE + GFX_SIZE + PROM_SIZE;
  localparam int HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;

  localparam logic [24:0] TOTAL_C   = 25'(TOTAL);
  localparam logic [24:0] GFX_BASE  = 25'(PRG_SIZE);
  localparam logic [24:0] PROM_BASE = 25'(PRG_SIZE + GFX_SIZE);
  localparam logic [14:0] GFX_OFF   = 15'(PRG_SIZE);
  localparam logic [14:0] PROM_OFF  = 15'(PRG_SIZE + GFX_SIZE);
  localparam logic [24:0] CNT_ONE   = 25'd1;
  localparam logic [7:0]  ROM_IDX   = 8'(ROM_INDEX);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]        state;
  logic              dl_q;
  logic [24:0]       byte_cnt;
  logic [24:0]       cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt;

  logic        dl_rise;
  logic        dl_fall;
  logic        start;
  logic        wr_ok;
  logic        in_prg;
  logic        in_gfx;
  logic [14:0] addr_rel;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign start   = dl_rise & (ioctl_index == ROM_IDX);

  // A write on the start cycle itself is treated as part of the new load.
  assign wr_ok  = ioctl_wr & (ioctl_addr < TOTAL_C) & (start | (state == S_LOAD));
  assign in_prg = ioctl_addr < GFX_BASE;
  assign in_gfx = ~in_prg & (ioctl_addr < PROM_BASE);

  always_comb begin
    addr_rel = ioctl_addr[14:0];
    if (in_gfx) begin
      addr_rel = ioctl_addr[14:0] - GFX_OFF;
    end else if (!in_prg) begin
      addr_rel = ioctl_addr[14:0] - PROM_OFF;
    end
  end

  // Count includes the write landing on the current cycle, so a final byte
  // coincident with the download falling edge counts toward completeness.
  always_comb begin
    cnt_nxt = start ? '0 : byte_cnt;
    if (wr_ok && (cnt_nxt != TOTAL_C)) begin
      cnt_nxt = cnt_nxt + CNT_ONE;
    end
  end

  // dl_q resets high so a download already in progress at reset release is
  // not mistaken for a fresh rising edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dl_q       <= 1'b1;
      byte_cnt   <= '0;
      hold_cnt   <= '0;
      rom_loaded <= 1'b0;
    end else begin
      dl_q     <= ioctl_download;
      byte_cnt <= cnt_nxt;
      if (start) begin
        state <= S_LOAD;
      end else begin
        case (state)
          S_LOAD: begin
            if (dl_fall) begin
              if (cnt_nxt == TOTAL_C) begin
                state    <= S_HOLD;
                hold_cnt <= HOLD_INIT;
              end else begin
                state <= S_ERR;
              end
            end
          end
          S_HOLD: begin
            if (ext_reset) begin
              hold_cnt <= HOLD_INIT;
            end else if (hold_cnt == '0) begin
              state      <= S_RUN;
              rom_loaded <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
          S_RUN: begin
            if (ext_reset) begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_INIT;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Write path: one register stage between ioctl_wr and the region strobe.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prg_we   <= 1'b0;
      gfx_we   <= 1'b0;
      prom_we  <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      prg_we  <= wr_ok & in_prg;
      gfx_we  <= wr_ok & in_gfx;
      prom_we <= wr_ok & ~in_prg & ~in_gfx;
      if (wr_ok) begin
        rom_addr <= addr_rel;
        rom_data <= ioctl_dout;
      end
    end
  end

  assign core_reset = (state != S_RUN) | ext_reset;
  assign load_error = (state == S_ERR);

endmodule
